// File: rtl/if_id_hazard_ctrl.sv
// if_id_hazard_ctrl: IF/ID and PC sequencing for load-use stalls, branch flushes and imem waits.
// Define IF_ID_HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module if_id_hazard_ctrl #(
  parameter int LU_STALL_CYC = 1,
  parameter int FLUSH_CYC    = 1,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       ctrl_state,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
);
  localparam logic [1:0] RUN = 2'd0, LU_STALL = 2'd1, FLUSH = 2'd2;
  localparam logic [2:0] LU_LOAD = 3'(LU_STALL_CYC > 1 ? LU_STALL_CYC - 2 : 0);
  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYC > 1 ? FLUSH_CYC - 2 : 0);
  logic [1:0] state, st, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic lu_hit;
  assign st = state == 2'd3 ? RUN : state;
  assign lu_hit = id_ex_mem_read && id_ex_rt != '0 &&
                  (id_ex_rt == id_rs || (id_uses_rt && id_ex_rt == id_rt));
  // branch_taken wins in every state; lu_hit only matters from RUN
  always_comb begin
    state_nx = branch_taken ? (FLUSH_CYC > 1 ? FLUSH : RUN) :
               st == RUN ? ((lu_hit && LU_STALL_CYC > 1) ? LU_STALL : RUN) :
               cnt != '0 ? st : RUN;
    cnt_nx   = branch_taken ? FL_LOAD :
               st == RUN ? ((lu_hit && LU_STALL_CYC > 1) ? LU_LOAD : 3'd0) :
               cnt != '0 ? cnt - 3'd1 : 3'd0;
  end
  always_comb begin
    pc_write     = reset ? 1'b0 : branch_taken ? 1'b1 : st == FLUSH ? imem_ready :
                   st == LU_STALL ? 1'b0 : !lu_hit && imem_ready;
    if_id_write  = !reset && (branch_taken || st == FLUSH || (st == RUN && !lu_hit));
    if_id_flush  = reset || branch_taken || st == FLUSH || (st == RUN && !lu_hit && !imem_ready);
    id_ex_bubble = reset || branch_taken || st != RUN || lu_hit;
    ctrl_state   = reset ? RUN : st;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
`ifdef IF_ID_HAZARD_PERF_EN
  // memory-wait NOPs are excluded from flush_cnt: only branch or FLUSH-state flushes count
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && !if_id_write && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if ((branch_taken || st == FLUSH) && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// tb_if_id_hazard_ctrl: table-driven scoreboard bench for if_id_hazard_ctrl (LU_STALL_CYC=3, FLUSH_CYC=2).
module tb_if_id_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_ex_rt = '0;
  logic id_uses_rt = 1'b0, id_ex_mem_read = 1'b0, branch_taken = 1'b0, imem_ready = 1'b1;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0] ctrl_state;
  logic [31:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  int exp_sc = 0, exp_fc = 0;
`ifdef IF_ID_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  if_id_hazard_ctrl #(.LU_STALL_CYC(3), .FLUSH_CYC(2), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // exp = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state}
  typedef struct {
    string name;
    logic rst;
    logic [4:0] rs, rt;
    logic ur, mr;
    logic [4:0] ex_rt;
    logic br, rdy;
    logic [5:0] exp;
  } vec_t;
  typedef struct { string name; logic [5:0] o; } sb_t;
  vec_t tbl[$];
  sb_t sb[$];

  function automatic vec_t mk(string n, logic rst, logic [4:0] rs, logic [4:0] rt, logic ur,
                              logic mr, logic [4:0] ex_rt, logic br, logic rdy, logic [5:0] exp);
    vec_t v;
    v.name = n; v.rst = rst; v.rs = rs; v.rt = rt; v.ur = ur; v.mr = mr;
    v.ex_rt = ex_rt; v.br = br; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk);
    reset = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ur; id_ex_mem_read = v.mr;
    id_ex_rt = v.ex_rt; branch_taken = v.br; imem_ready = v.rdy;
    sb.push_back('{v.name, v.exp});
    #2;
    checks++;
    if (stall_cnt !== (PERF ? 32'(exp_sc) : 32'd0) || flush_cnt !== (PERF ? 32'(exp_fc) : 32'd0)) begin
      errors++;
      $display("FAIL %s counters: got stall=%0d flush=%0d, want stall=%0d flush=%0d", v.name,
               stall_cnt, flush_cnt, PERF ? exp_sc : 0, PERF ? exp_fc : 0);
    end
    e = sb.pop_front();
    checks++;
    if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state} !== e.o) begin
      errors++;
      $display("FAIL %s outputs {pc_w,ifid_w,flush,bubble,state}: got %b, want %b", e.name,
               {pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state}, e.o);
    end
    if (v.rst) begin
      exp_sc = 0; exp_fc = 0;
    end else begin
      if (!v.exp[5] && !v.exp[4]) exp_sc++;
      if (v.exp[3] && (v.br || v.exp[1:0] == 2'd2)) exp_fc++;
    end
  endtask

  initial begin
    //                  name        rst rs     rt     ur    mr    ex_rt  br    rdy   pw iw fl bb st
    tbl.push_back(mk("reset",       1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b0011_00));
    tbl.push_back(mk("idle0",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("lu_c1",       0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 6'b0001_00));
    tbl.push_back(mk("lu_c2",       0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 6'b0001_01));
    tbl.push_back(mk("lu_c3",       0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 6'b0001_01));
    tbl.push_back(mk("lu_done",     0, 5'd5, 5'd2, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("r0_nohaz",    0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("rt_unused",   0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("rt_hit",      0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 6'b0001_00));
    tbl.push_back(mk("rt_c2",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b0001_01));
    tbl.push_back(mk("rt_c3",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b0001_01));
    tbl.push_back(mk("idle1",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("br_c1",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 6'b1111_00));
    tbl.push_back(mk("br_c2",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1111_10));
    tbl.push_back(mk("br_done",     0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("br_lu_wait",  0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 6'b1111_00));
    tbl.push_back(mk("fl_ign_lu",   0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 6'b0111_10));
    tbl.push_back(mk("idle2",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("abort_c1",    0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 6'b0001_00));
    tbl.push_back(mk("abort_br",    0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 6'b1111_01));
    tbl.push_back(mk("abort_fl",    0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1111_10));
    tbl.push_back(mk("idle3",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("rebr_c1",     0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 6'b1111_00));
    tbl.push_back(mk("rebr_again",  0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 6'b1111_10));
    tbl.push_back(mk("rebr_last",   0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1111_10));
    tbl.push_back(mk("idle4",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("mem_wait",  0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b0110_00));
    tbl.push_back(mk("idle5",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("rs_lu_c1",    0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 6'b0001_00));
    tbl.push_back(mk("rst_stall1",  1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 6'b0011_00));
    tbl.push_back(mk("rst_stall2",  1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 6'b0011_00));
    tbl.push_back(mk("post_rst",    0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    tbl.push_back(mk("rf_br",       0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 6'b1111_00));
    tbl.push_back(mk("rst_flush",   1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b0011_00));
    tbl.push_back(mk("post_rst2",   0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    foreach (tbl[i]) apply(tbl[i]);
    // hand-written tail: back-to-back load-use hazards, each costing the full 3 cycles
    for (int k = 0; k < 2; k++) begin
      apply(mk("b2b_c1", 0, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 6'b0001_00));
      apply(mk("b2b_c2", 0, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 6'b0001_01));
      apply(mk("b2b_c3", 0, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 6'b0001_01));
    end
    apply(mk("b2b_end", 0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b1100_00));
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- Sequencing controller for the IF/ID pipeline register and the PC.
- Generates pc_write, if_id_write, if_id_flush and id_ex_bubble from three sources: load-use hazard detection, taken-branch redirect from EX, and the instruction-memory ready handshake.
- Holds a small FSM with cycle counters so that multi-cycle load-use stalls and multi-cycle branch flushes are sequenced without help from the datapath.

Parameters:
- LU_STALL_CYC, 1, total stall cycles per load-use hazard; legal range 1..7.
- FLUSH_CYC, 1, total flush cycles per taken branch; legal range 1..3.
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  REG_W  destination rt of the instruction in EX.
- branch_taken  in  1  branch in EX resolved as taken this cycle.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable; 0 holds IF/ID.
- if_id_flush  out  1  IF/ID loads all-zero (NOP) at the next edge.
- id_ex_bubble  out  1  ID/EX control fields forced to zero.
- ctrl_state  out  2  FSM state: RUN=0, LU_STALL=1, FLUSH=2.
- stall_cnt  out  32  load-use stall cycle counter (see Optional Feature).
- flush_cnt  out  32  flush cycle counter (see Optional Feature).

Behaviour:
- State and counter are registered. pc_write, if_id_write, if_id_flush and id_ex_bubble are combinational from state and inputs (Mealy), so a response takes effect at the same edge.
- Load-use hit: lu_hit = id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == id_rs || (id_uses_rt && id_ex_rt == id_rt)).
- Default outputs (RUN, no event): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- RUN, priority branch_taken > lu_hit > !imem_ready:
  - branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1. If FLUSH_CYC>1, go to FLUSH with cnt=FLUSH_CYC-2; otherwise stay in RUN.
  - lu_hit: pc_write=0, if_id_write=0, id_ex_bubble=1. If LU_STALL_CYC>1, go to LU_STALL with cnt=LU_STALL_CYC-2; otherwise stay in RUN.
  - !imem_ready: pc_write=0, if_id_write=1, if_id_flush=1. IF/ID receives a NOP, and the ID instruction advances normally. No state change.
- LU_STALL:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - cnt==0: return to RUN. Otherwise decrement cnt.
  - branch_taken here aborts the stall and behaves exactly as branch_taken in RUN, including entry to FLUSH.
- FLUSH:
  - Outputs: if_id_flush=1, id_ex_bubble=1, pc_write=imem_ready.
  - cnt==0: return to RUN. Otherwise decrement cnt.
  - A new branch_taken reloads cnt=FLUSH_CYC-2 and remains in FLUSH, or goes to RUN when FLUSH_CYC==1.
  - lu_hit is ignored in FLUSH.
- if_id_flush dominates if_id_write whenever both are asserted.
- Reset (synchronous, any state, mid-stall or mid-flush):
  - Next state is RUN with cnt=0, and counters are cleared.
  - In the reset cycle the outputs are pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ctrl_state=0.
- id_rs or id_rt equal to 0 never matches, because id_ex_rt==0 is excluded.
- Illegal state 3: treat as RUN and move to RUN at the next edge.

Optional Feature:
- Macro: IF_ID_HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments once per cycle in which pc_write=0 and if_id_write=0 (load-use stall cycles).
  - flush_cnt increments once per cycle with if_id_flush=1 caused by branch_taken or the FLUSH state. Memory-wait NOPs are not counted.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter logic is built.

Test Plan:
- Reset: reset=1 for 2 cycles while in LU_STALL → ctrl_state=0, pc_write=0, if_id_flush=1, id_ex_bubble=1; after release with no events → pc_write=1, if_id_write=1, flush=0.
- Load-use, LU_STALL_CYC=3: id_ex_mem_read=1, id_ex_rt=5, id_rs=5 → exactly 3 cycles with pc_write=0, if_id_write=0, id_ex_bubble=1, ctrl_state 0→1→1→0; stall_cnt=3 with macro defined.
- No false hazard: id_ex_rt=0, id_rs=0, mem_read=1 → no stall. id_ex_rt=7, id_rt=7, id_uses_rt=0 → no stall.
- Branch, FLUSH_CYC=2: branch_taken=1 for one cycle → 2 cycles of if_id_flush=1 and id_ex_bubble=1, pc_write=1 in the first cycle; flush_cnt=2.
- Simultaneous events: branch_taken=1 with lu_hit=1 and imem_ready=0 → branch wins (flush=1, pc_write=1). Branch during LU_STALL cycle 2 → stall aborted, ctrl_state=2 or 0 per FLUSH_CYC.
- Memory wait: imem_ready=0 for 4 cycles in RUN → pc_write=0 and if_id_flush=1 for 4 cycles, ctrl_state=0 throughout, stall_cnt unchanged.
